fir_packet_master: RTL and testbench
====================================

FIR_PACKET_MASTER -- requirements
Module: fir_packet_master

Interface
REQ-001 SHALL have parameter SAMPLES_NUM, default 8: 16-bit samples per packet, legal 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 16: clk cycles per sck half-period, legal 8..255.
REQ-003 SHALL have parameter CS_GAP, default 16: clk cycles ssOut held high after each packet, legal 1..255.
REQ-004 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port nResetIn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port startIn  in  1  single-cycle request to send one packet.
REQ-007 SHALL have port abortIn  in  1  abort the current packet.
REQ-008 SHALL have port dataIn  in  16*SAMPLES_NUM  samples; sample 0 in the MSBs.
REQ-009 SHALL have port dataOut  out  32*SAMPLES_NUM  received results; result 0 in the MSBs.
REQ-010 SHALL have port doneOut  out  1  one-cycle pulse when dataOut is updated.
REQ-011 SHALL have port busyOut  out  1  packet or gap in progress.
REQ-012 SHALL have port ssOut  out  1  SPI slave select, active-low.
REQ-013 SHALL have port sckOut  out  1  SPI clock, cpol=0.
REQ-014 SHALL have port mosiOut  out  1  SPI data to slave.
REQ-015 SHALL have port misoIn  in  1  SPI data from slave.

Function
REQ-016 SHALL be an SPI master, cpol=0/cpha=0, MSB first, NBITS = 32*SAMPLES_NUM bits per packet.
REQ-017 SHALL form the tx frame as {dataIn, 16*SAMPLES_NUM zero bits}: samples first, then SAMPLES_NUM*2 zero don't-care bytes.
REQ-018 SHALL implement the states IDLE, LOW, HIGH, TRAIL and GAP.
REQ-019 IDLE: on startIn=1, SHALL latch the tx frame, drive ssOut=0, drive mosiOut=frame MSB, set busyOut=1, clear the bit counter, and go to LOW on the next cycle.
REQ-020 LOW: sckOut=0 for CLK_DIV cycles; on the last cycle SHALL set sckOut=1, shift misoIn into the rx register LSB, and go to HIGH.
REQ-021 HIGH: sckOut=1 for CLK_DIV cycles; on the last cycle SHALL set sckOut=0.
REQ-022 At the end of HIGH, if bits sent < NBITS, SHALL shift the tx register, drive the next bit on mosiOut (same cycle as the sck fall), and go to LOW.
REQ-023 At the end of HIGH, if bits sent = NBITS, SHALL go to TRAIL.
REQ-024 TRAIL: after CLK_DIV cycles SHALL set ssOut=1, load dataOut from the rx register, pulse doneOut for 1 cycle, and go to GAP.
REQ-025 GAP: SHALL hold ssOut=1, sckOut=0, mosiOut=0 for CS_GAP cycles, then go to IDLE with busyOut=0.
REQ-026 startIn SHALL be ignored whenever busyOut=1; there is no request queuing.
REQ-027 abortIn=1 in LOW, HIGH or TRAIL SHALL next cycle force ssOut=1, sckOut=0, mosiOut=0, enter GAP, and leave dataOut unchanged with no doneOut.
REQ-028 abortIn SHALL be ignored in IDLE and GAP.
REQ-029 If abortIn and the TRAIL completion occur in the same cycle, abort SHALL win.
REQ-030 Packet length from the startIn cycle to doneOut SHALL be exactly 1 + 2*CLK_DIV*NBITS + CLK_DIV cycles.
REQ-031 The result stream SHALL be delayed by the slave's pipeline; this block SHALL NOT reorder or interpret it.
REQ-032 dataOut SHALL hold its value until the next doneOut.
REQ-033 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-034 nResetIn=0 SHALL asynchronously force state IDLE, ssOut=1, sckOut=0, mosiOut=0, doneOut=0, busyOut=0, dataOut=0, counters 0.
REQ-035 Reset mid-packet SHALL abandon the packet with no doneOut; the first startIn after release SHALL begin a complete new packet.

Verification (SAMPLES_NUM=2, CLK_DIV=8, CS_GAP=4)
REQ-036 Bench SHALL cover loopback (misoIn=mosiOut), dataIn=32'h1234ABCD -> dataOut=64'h1234ABCD_00000000, doneOut once at cycle 1+1024+8=1033.
REQ-037 Bench SHALL cover misoIn tied 1, dataIn=0 -> mosiOut constant 0, 64 sck rising edges, dataOut=64'hFFFFFFFF_FFFFFFFF.
REQ-038 Bench SHALL cover startIn pulsed again at packet bit 10 and during GAP -> both ignored, exactly one packet, busyOut=1 throughout.
REQ-039 Bench SHALL cover abortIn at bit 20 -> ssOut=1 and sckOut=0 next cycle, no doneOut, dataOut keeps its prior value, busyOut=0 after 4 GAP cycles.
REQ-040 Bench SHALL cover nResetIn low at bit 30 -> all outputs at reset values immediately; a new start gives a correct 64-bit loopback result.
REQ-041 Bench SHALL cover back-to-back starts issued on the first IDLE cycle -> ssOut high for exactly CS_GAP+1 cycles between packets.

Source files
------------

// File: rtl/fir_packet_master.sv
// fir_packet_master: mode-0 SPI master that streams one packet of FIR samples
// to a slave and captures the equally long result stream coming back.
module fir_packet_master #(
    parameter int SAMPLES_NUM = 8,
    parameter int CLK_DIV     = 16,
    parameter int CS_GAP      = 16
) (
    input  logic                      clk,
    input  logic                      nResetIn,
    input  logic                      startIn,
    input  logic                      abortIn,
    input  logic [16*SAMPLES_NUM-1:0] dataIn,
    output logic [32*SAMPLES_NUM-1:0] dataOut,
    output logic                      doneOut,
    output logic                      busyOut,
    output logic                      ssOut,
    output logic                      sckOut,
    output logic                      mosiOut,
    input  logic                      misoIn
);
    localparam int DW    = 16*SAMPLES_NUM;
    localparam int NBITS = 32*SAMPLES_NUM;
    localparam int BW    = $clog2(NBITS + 1);

    localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(NBITS - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, TRAIL, GAP} state_t;

    state_t           state, stateNext;
    logic [7:0]       divCnt, divCntNext;
    logic [BW-1:0]    bitCnt, bitCntNext;
    logic [NBITS-1:0] txReg, txNext;
    logic [NBITS-1:0] rxReg, rxNext;
    logic [NBITS-1:0] dataNext;
    logic             ssNext, sckNext, mosiNext;
    logic             doneNext, busyNext;
    logic             divLast, gapLast, lastBit;

    assign divLast = (divCnt == DIV_LAST);
    assign gapLast = (divCnt == GAP_LAST);
    assign lastBit = (bitCnt == BITS_LAST);

    always_ff @(posedge clk or negedge nResetIn) begin
        if (!nResetIn) begin
            state   <= IDLE;
            divCnt  <= '0;
            bitCnt  <= '0;
            txReg   <= '0;
            rxReg   <= '0;
            dataOut <= '0;
            ssOut   <= 1'b1;
            sckOut  <= 1'b0;
            mosiOut <= 1'b0;
            doneOut <= 1'b0;
            busyOut <= 1'b0;
        end else begin
            state   <= stateNext;
            divCnt  <= divCntNext;
            bitCnt  <= bitCntNext;
            txReg   <= txNext;
            rxReg   <= rxNext;
            dataOut <= dataNext;
            ssOut   <= ssNext;
            sckOut  <= sckNext;
            mosiOut <= mosiNext;
            doneOut <= doneNext;
            busyOut <= busyNext;
        end
    end

    // Abort is checked first so it beats a coincident TRAIL completion.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (startIn) stateNext = LOW;
            LOW: begin
                if (abortIn)      stateNext = GAP;
                else if (divLast) stateNext = HIGH;
            end
            HIGH: begin
                if (abortIn)      stateNext = GAP;
                else if (divLast) stateNext = lastBit ? TRAIL : LOW;
            end
            TRAIL: begin
                if (abortIn)      stateNext = GAP;
                else if (divLast) stateNext = GAP;
            end
            GAP:   if (gapLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        divCntNext = (state == IDLE || stateNext != state) ? 8'd0 : divCnt + 8'd1;
        bitCntNext = bitCnt;
        txNext     = txReg;
        rxNext     = rxReg;
        dataNext   = dataOut;
        ssNext     = ssOut;
        sckNext    = sckOut;
        mosiNext   = mosiOut;
        doneNext   = 1'b0;
        busyNext   = busyOut;
        unique case (state)
            IDLE: begin
                if (startIn) begin
                    txNext     = {dataIn, {DW{1'b0}}};
                    ssNext     = 1'b0;
                    mosiNext   = dataIn[DW-1];
                    busyNext   = 1'b1;
                    bitCntNext = '0;
                end
            end
            LOW, HIGH, TRAIL: begin
                if (abortIn) begin
                    ssNext   = 1'b1;
                    sckNext  = 1'b0;
                    mosiNext = 1'b0;
                end else if (divLast) begin
                    if (state == LOW) begin
                        sckNext = 1'b1;
                        rxNext  = {rxReg[NBITS-2:0], misoIn};
                    end else if (state == HIGH) begin
                        sckNext    = 1'b0;
                        bitCntNext = bitCnt + BW'(1);
                        if (!lastBit) begin
                            txNext   = {txReg[NBITS-2:0], 1'b0};
                            mosiNext = txReg[NBITS-2];
                        end
                    end else begin
                        ssNext   = 1'b1;
                        mosiNext = 1'b0;
                        dataNext = rxReg;
                        doneNext = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gapLast) busyNext = 1'b0;
            end
            default: busyNext = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fir_packet_master.sv
// Directed bench for fir_packet_master with SAMPLES_NUM=2, CLK_DIV=8, CS_GAP=4.
module tb_fir_packet_master;
    logic        clk = 1'b0;
    logic        nResetIn;
    logic        startIn;
    logic        abortIn;
    logic [31:0] dataIn;
    logic [63:0] dataOut;
    logic        doneOut;
    logic        busyOut;
    logic        ssOut;
    logic        sckOut;
    logic        mosiOut;
    logic        misoIn;
    logic        loopMode;
    logic        misoConst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign misoIn = loopMode ? mosiOut : misoConst;

    fir_packet_master #(
        .SAMPLES_NUM(2),
        .CLK_DIV(8),
        .CS_GAP(4)
    ) dut (
        .clk(clk),
        .nResetIn(nResetIn),
        .startIn(startIn),
        .abortIn(abortIn),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .doneOut(doneOut),
        .busyOut(busyOut),
        .ssOut(ssOut),
        .sckOut(sckOut),
        .mosiOut(mosiOut),
        .misoIn(misoIn)
    );

    task automatic test_reset();
        nResetIn  = 1'b0;
        startIn   = 1'b0;
        abortIn   = 1'b0;
        dataIn    = '0;
        loopMode  = 1'b1;
        misoConst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ssOut !== 1'b1) begin
            errors++; $display("FAIL reset_ss: got %b expected 1", ssOut);
        end
        checks++;
        if (sckOut !== 1'b0 || mosiOut !== 1'b0) begin
            errors++; $display("FAIL reset_sck_mosi: got %b%b expected 00", sckOut, mosiOut);
        end
        checks++;
        if (doneOut !== 1'b0 || busyOut !== 1'b0) begin
            errors++; $display("FAIL reset_done_busy: got %b%b expected 00", doneOut, busyOut);
        end
        checks++;
        if (dataOut !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", dataOut);
        end
        @(negedge clk);
        nResetIn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busyOut !== 1'b0 || ssOut !== 1'b1) begin
            errors++; $display("FAIL idle_after_release: busy=%b ss=%b expected 0 1", busyOut, ssOut);
        end
    endtask

    task automatic test_loopback();
        int cyc = 0;
        int doneCyc = -1;
        int dones = 0;
        loopMode = 1'b1;
        dataIn   = 32'h1234ABCD;
        @(negedge clk);
        startIn = 1'b1;
        while (cyc < 1200 && !(dones > 0 && !busyOut)) begin
            @(posedge clk); #1; cyc++;
            startIn = 1'b0;
            if (doneOut) begin
                dones++;
                if (doneCyc < 0) doneCyc = cyc;
            end
        end
        checks++;
        if (cyc >= 1200) begin
            errors++; $display("FAIL loop_timeout: cycles %0d limit 1200", cyc);
        end
        checks++;
        if (doneCyc != 1033) begin
            errors++; $display("FAIL loop_latency: got %0d expected 1033", doneCyc);
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL loop_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (dataOut !== 64'h1234ABCD_00000000) begin
            errors++; $display("FAIL loop_data: got %h expected 1234abcd00000000", dataOut);
        end
        checks++;
        if (cyc != 1037) begin
            errors++; $display("FAIL loop_busy_fall: got %0d expected 1037", cyc);
        end
    endtask

    task automatic test_ones();
        int cyc = 0;
        int dones = 0;
        int rises = 0;
        int mosiHigh = 0;
        logic prevSck = 1'b0;
        loopMode  = 1'b0;
        misoConst = 1'b1;
        dataIn    = 32'h0;
        @(negedge clk);
        startIn = 1'b1;
        while (cyc < 1200 && !(dones > 0 && !busyOut)) begin
            @(posedge clk); #1; cyc++;
            startIn = 1'b0;
            if (sckOut && !prevSck) rises++;
            prevSck = sckOut;
            if (mosiOut !== 1'b0) mosiHigh++;
            if (doneOut) dones++;
        end
        checks++;
        if (cyc >= 1200) begin
            errors++; $display("FAIL ones_timeout: cycles %0d limit 1200", cyc);
        end
        checks++;
        if (rises != 64) begin
            errors++; $display("FAIL ones_sck_rises: got %0d expected 64", rises);
        end
        checks++;
        if (mosiHigh != 0) begin
            errors++; $display("FAIL ones_mosi: got %0d high cycles expected 0", mosiHigh);
        end
        checks++;
        if (dataOut !== 64'hFFFFFFFF_FFFFFFFF) begin
            errors++; $display("FAIL ones_data: got %h expected ffffffffffffffff", dataOut);
        end
        misoConst = 1'b0;
        loopMode  = 1'b1;
    endtask

    task automatic test_ignore_start();
        int cyc = 0;
        int dones = 0;
        int doneCyc = -1;
        int ssLow = 0;
        loopMode = 1'b1;
        dataIn   = 32'hA5A50F0F;
        @(negedge clk);
        startIn = 1'b1;
        while (cyc < 1200 && !(dones > 0 && !busyOut)) begin
            @(posedge clk); #1; cyc++;
            startIn = (cyc == 161 || cyc == 1035);
            if (doneOut) begin
                dones++;
                if (doneCyc < 0) doneCyc = cyc;
            end
        end
        startIn = 1'b0;
        checks++;
        if (cyc != 1037) begin
            errors++; $display("FAIL ign_busy_span: busy fell at %0d expected 1037", cyc);
        end
        checks++;
        if (doneCyc != 1033) begin
            errors++; $display("FAIL ign_latency: got %0d expected 1033", doneCyc);
        end
        repeat (30) begin
            @(posedge clk); #1;
            if (ssOut !== 1'b1 || busyOut !== 1'b0) ssLow++;
            if (doneOut) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL ign_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (ssLow != 0) begin
            errors++; $display("FAIL ign_restart: got %0d active cycles expected 0", ssLow);
        end
        checks++;
        if (dataOut !== 64'hA5A50F0F_00000000) begin
            errors++; $display("FAIL ign_data: got %h expected a5a50f0f00000000", dataOut);
        end
    endtask

    task automatic test_abort();
        int cyc = 0;
        int dones = 0;
        logic busyA = 1'b0;
        logic busyB = 1'b1;
        loopMode = 1'b1;
        dataIn   = 32'hDEADBEEF;
        @(negedge clk);
        startIn = 1'b1;
        while (cyc < 340) begin
            @(posedge clk); #1; cyc++;
            startIn = 1'b0;
            if (doneOut) dones++;
            if (cyc == 322) begin
                checks++;
                if (ssOut !== 1'b1 || sckOut !== 1'b0 || mosiOut !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_lines: ss/sck/mosi %b%b%b expected 100",
                             ssOut, sckOut, mosiOut);
                end
            end
            if (cyc == 325) busyA = busyOut;
            if (cyc == 326) busyB = busyOut;
            abortIn = (cyc == 321);
        end
        checks++;
        if (busyA !== 1'b1 || busyB !== 1'b0) begin
            errors++; $display("FAIL abort_gap: busy at 325/326 %b%b expected 10", busyA, busyB);
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL abort_done: got %0d expected 0", dones);
        end
        checks++;
        if (dataOut !== 64'hA5A50F0F_00000000) begin
            errors++; $display("FAIL abort_data: got %h expected a5a50f0f00000000", dataOut);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int dones = 0;
        int doneCyc = -1;
        loopMode = 1'b1;
        dataIn   = 32'h0BADF00D;
        @(negedge clk);
        startIn = 1'b1;
        while (cyc < 481) begin
            @(posedge clk); #1; cyc++;
            startIn = 1'b0;
        end
        nResetIn = 1'b0;
        #1;
        checks++;
        if (ssOut !== 1'b1 || sckOut !== 1'b0 || mosiOut !== 1'b0 ||
            doneOut !== 1'b0 || busyOut !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_lines: ss/sck/mosi/done/busy %b%b%b%b%b expected 10000",
                     ssOut, sckOut, mosiOut, doneOut, busyOut);
        end
        checks++;
        if (dataOut !== 64'h0) begin
            errors++; $display("FAIL rst_mid_data: got %h expected 0", dataOut);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        nResetIn = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (doneOut || busyOut) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", dones);
        end
        dataIn = 32'hCAFE1234;
        @(negedge clk);
        startIn = 1'b1;
        cyc = 0;
        while (cyc < 1200 && !(dones > 0 && !busyOut)) begin
            @(posedge clk); #1; cyc++;
            startIn = 1'b0;
            if (doneOut) begin
                dones++;
                if (doneCyc < 0) doneCyc = cyc;
            end
        end
        checks++;
        if (doneCyc != 1033) begin
            errors++; $display("FAIL rst_new_latency: got %0d expected 1033", doneCyc);
        end
        checks++;
        if (dataOut !== 64'hCAFE1234_00000000) begin
            errors++; $display("FAIL rst_new_data: got %h expected cafe123400000000", dataOut);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int dones = 0;
        int ssHigh = 0;
        int start2Cyc = -1;
        int done2Cyc = -1;
        bit started2 = 1'b0;
        bit issued = 1'b0;
        loopMode = 1'b1;
        dataIn   = 32'h11112222;
        @(negedge clk);
        startIn = 1'b1;
        while (cyc < 2500 && dones < 2) begin
            @(posedge clk); #1; cyc++;
            startIn = 1'b0;
            if (doneOut) begin
                dones++;
                if (dones == 1) begin
                    checks++;
                    if (dataOut !== 64'h11112222_00000000) begin
                        errors++;
                        $display("FAIL b2b_data1: got %h expected 1111222200000000", dataOut);
                    end
                end else begin
                    done2Cyc = cyc;
                end
            end
            if (dones == 1 && !started2) begin
                if (ssOut) ssHigh++;
                else started2 = 1'b1;
            end
            if (dones == 1 && !busyOut && !issued) begin
                issued    = 1'b1;
                start2Cyc = cyc;
                dataIn    = 32'h33334444;
                startIn   = 1'b1;
            end
        end
        startIn = 1'b0;
        checks++;
        if (cyc >= 2500) begin
            errors++; $display("FAIL b2b_timeout: cycles %0d limit 2500", cyc);
        end
        checks++;
        if (ssHigh != 5) begin
            errors++; $display("FAIL b2b_ss_gap: got %0d expected 5", ssHigh);
        end
        checks++;
        if (done2Cyc - start2Cyc != 1033) begin
            errors++;
            $display("FAIL b2b_latency2: got %0d expected 1033", done2Cyc - start2Cyc);
        end
        checks++;
        if (dataOut !== 64'h33334444_00000000) begin
            errors++; $display("FAIL b2b_data2: got %h expected 3333444400000000", dataOut);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_ones();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
